// File: rtl/par_ring_buffer_pkg.sv
// Shared sizing helpers and parameter-legality rule for the parallel ring buffer
// and any block that must agree with it on depth and occupancy width.
package par_ring_buffer_pkg;

    // Number of storage slots addressed by a pointer of the given width.
    function automatic int depth_of(input int pointer_size);
        return 1 << pointer_size;
    endfunction

    // Occupancy needs one bit more than a pointer so that 0..DEPTH all fit.
    function automatic int count_w_of(input int pointer_size);
        return pointer_size + 1;
    endfunction

    // Group sizes must be non-zero and must fit inside the ring.
    function automatic bit par_legal(input int pointer_size, input int par_write,
                                     input int par_read);
        return (par_write >= 1) && (par_read >= 1) &&
               (par_write <= depth_of(pointer_size)) &&
               (par_read <= depth_of(pointer_size));
    endfunction

endpackage

// File: rtl/par_ring_buffer_if.sv
// Producer/consumer side bundle of the parallel ring buffer.
interface par_ring_buffer_if
    import par_ring_buffer_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int POINTER_SIZE = 3,
    parameter int PAR_WRITE    = 2,
    parameter int PAR_READ     = 4
);
    localparam int COUNT_W = count_w_of(POINTER_SIZE);

    logic                            wr_en;
    logic [PAR_WRITE*DATA_WIDTH-1:0] wr_data;
    logic                            wr_ready;
    logic                            rd_en;
    logic [PAR_READ*DATA_WIDTH-1:0]  rd_data;
    logic                            rd_valid;
    logic [COUNT_W-1:0]              level;
    logic                            full;
    logic                            empty;
    logic                            wr_overflow;
    logic                            rd_underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  wr_ready, rd_data, rd_valid, level, full, empty,
               wr_overflow, rd_underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output wr_ready, rd_data, rd_valid, level, full, empty,
               wr_overflow, rd_underflow
    );

endinterface

// File: rtl/par_ring_buffer_ctrl.sv
// Pointer, occupancy and protocol-error control for the parallel ring buffer.
// All status outputs decode the registered count only.
module par_ring_ctrl
    import par_ring_buffer_pkg::*;
#(
    parameter int POINTER_SIZE = 3,
    parameter int PAR_WRITE    = 2,
    parameter int PAR_READ     = 4,
    localparam int COUNT_W     = count_w_of(POINTER_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    rd_en,
    output logic [POINTER_SIZE-1:0] wr_ptr,
    output logic [POINTER_SIZE-1:0] rd_ptr,
    output logic                    wr_accept,
    output logic [COUNT_W-1:0]      level,
    output logic                    wr_ready,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    wr_overflow,
    output logic                    rd_underflow
);
    localparam int DEPTH = depth_of(POINTER_SIZE);

    logic [COUNT_W-1:0] count;
    logic [COUNT_W:0]   count_wide;
    logic               rd_accept;

    assign level     = count;
    assign wr_ready  = (count <= COUNT_W'(DEPTH - PAR_WRITE));
    assign rd_valid  = (count >= COUNT_W'(PAR_READ));
    assign full      = (count == COUNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign wr_accept = wr_en & wr_ready;
    assign rd_accept = rd_en & rd_valid;

    // Next occupancy, one bit wider so the intermediate never wraps.
    always_comb begin
        count_wide = {1'b0, count};
        if (wr_accept) count_wide = count_wide + (COUNT_W+1)'(PAR_WRITE);
        if (rd_accept) count_wide = count_wide - (COUNT_W+1)'(PAR_READ);
    end

    // Pointer, count and sticky-error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            wr_overflow  <= 1'b0;
            rd_underflow <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + POINTER_SIZE'(PAR_WRITE);
            if (rd_accept) rd_ptr <= rd_ptr + POINTER_SIZE'(PAR_READ);
            count <= COUNT_W'(count_wide);
            if (wr_en && !wr_ready) wr_overflow  <= 1'b1;
            if (rd_en && !rd_valid) rd_underflow <= 1'b1;
        end
    end

endmodule

// File: rtl/par_ring_buffer.sv
// Circular buffer pushing PAR_WRITE words per write and popping PAR_READ words
// per read, with show-ahead read data and sticky protocol-error flags.
module par_ring_buffer
    import par_ring_buffer_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int POINTER_SIZE = 3,
    parameter int PAR_WRITE    = 2,
    parameter int PAR_READ     = 4
) (
    input  logic              clk,
    input  logic              rst,
    par_ring_buffer_if.slave  bus
);
    localparam int DEPTH = depth_of(POINTER_SIZE);

    if (!par_legal(POINTER_SIZE, PAR_WRITE, PAR_READ)) begin : g_illegal
        $error("par_ring_buffer: PAR_WRITE/PAR_READ must lie in 1..DEPTH");
    end

    logic [DATA_WIDTH-1:0]          mem [DEPTH];
    logic [POINTER_SIZE-1:0]        wr_ptr;
    logic [POINTER_SIZE-1:0]        rd_ptr;
    logic                           wr_accept;
    logic [PAR_READ*DATA_WIDTH-1:0] rd_gather;

    par_ring_ctrl #(
        .POINTER_SIZE (POINTER_SIZE),
        .PAR_WRITE    (PAR_WRITE),
        .PAR_READ     (PAR_READ)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (bus.wr_en),
        .rd_en        (bus.rd_en),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .wr_accept    (wr_accept),
        .level        (bus.level),
        .wr_ready     (bus.wr_ready),
        .rd_valid     (bus.rd_valid),
        .full         (bus.full),
        .empty        (bus.empty),
        .wr_overflow  (bus.wr_overflow),
        .rd_underflow (bus.rd_underflow)
    );

    // Storage: clear on reset, scatter an accepted write group from wr_ptr onward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else if (wr_accept) begin
            for (int unsigned i = 0; i < PAR_WRITE; i++)
                mem[wr_ptr + POINTER_SIZE'(i)] <= bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Show-ahead gather of PAR_READ words starting at rd_ptr, wrapping modulo DEPTH.
    always_comb begin
        rd_gather = '0;
        for (int unsigned j = 0; j < PAR_READ; j++)
            rd_gather[j*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr + POINTER_SIZE'(j)];
    end

    assign bus.rd_data = rd_gather;

endmodule
